axilite_master: RTL and testbench
=================================

# axilite_master

Single-outstanding AXI4-Lite master that turns simple command-port requests into AXI-Lite read and write transactions and returns responses on a response port. It is the initiator counterpart of `axilite_sram_controller`. It sits between test/firmware-style command logic and any AXI-Lite slave, and is the standard bus driver for the SRAM controller in integrated benches.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; must be a multiple of 8
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  captured BRESP/RRESP
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI-Lite master ports with the same widths as the command port

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On cmd_valid, the block registers the command, goes to WR_REQ if cmd_write=1, else to RD_REQ.
- WR_REQ: awvalid and wvalid both rise in the cycle after acceptance. Each drops independently on its own handshake (awvalid&&awready, wvalid&&wready). The state exits to WR_RESP once both handshakes have completed, including when both complete in the same cycle.
- WR_RESP: bready=1. On bvalid, capture bresp, rsp_write=1, rsp_rdata=0, go to RSP.
- RD_REQ: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, rsp_write=0, go to RSP.
- RSP: rsp_valid=1 with stable payload until rsp_ready, then go to IDLE.
- Exactly one transaction is outstanding at a time. No new command is accepted before the response is consumed.
- AXI rules:
  - A VALID, once asserted, never deasserts before its READY.
  - Address, data and strobe are stable while VALID is high.
  - The master never waits for READY before asserting VALID.
- Addresses are passed through unmodified. No alignment or range check is made, and the slave reports errors.

## Timing
- Reset values: all m_axi valid/ready outputs 0, address/data/strobe registers 0, rsp_valid 0, rsp_resp 0, rsp_rdata 0, rsp_write 0, FSM in IDLE. cmd_ready=1 during and after reset.
- All AXI outputs and response outputs are driven from registers or decoded from the FSM state. There is no combinational path from slave inputs to master outputs.
- cmd_ready is decoded from the state (IDLE). It is not combinationally dependent on cmd_valid.
- Write latency with a zero-wait slave: cmd accepted at cycle 0 → AW/W valid at 1 → B handshake at 2 (from the controller's WR_RESP) → rsp_valid at 3.
- Read latency with a zero-wait slave: cmd at 0 → arvalid at 1 → rvalid at 2 → rsp_valid at 3.
- Back-to-back: after rsp_valid&&rsp_ready the FSM returns to IDLE, so the next command is accepted one cycle later at the earliest.
- Reset asserted mid-transaction aborts immediately. All outputs return to reset values and no response is produced. Slave recovery is the system's responsibility.

## Structure
- Shared package `axilite_pkg` holds:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - master FSM state enum type
- The SRAM controller migrates to the same response constants.
- No sub-module. The block is a single FSM plus payload registers. Per-channel "done" flags (aw_done, w_done) track the independent AW/W handshakes.

## Test plan
- Write cmd addr=0x10, wdata=0xDEADBEEF, wstrb=0xF to the SRAM controller (depth 1024). Required: one AW and one W handshake, rsp_write=1, rsp_resp=OKAY; rsp_valid exactly 3 cycles after acceptance.
- Read addr=0x10 after the above. Required: rsp_rdata=0xDEADBEEF, rsp_resp=OKAY, rsp_write=0.
- Write wstrb=0x3 of 0x11112222 over 0xDEADBEEF, then read. Required: rsp_rdata=0xDEAD2222.
- Read addr=0x0000_1000 (out of range). Required: rsp_resp=SLVERR, rsp_rdata=0.
- Slave model: awready delayed 3 cycles, wready immediate. Required: wvalid drops after 1 cycle, awvalid held 4 cycles with awaddr stable, exactly one B accepted.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1. Required: rsp payload stable and cmd_ready=0 throughout. Separately, assert rst_n low during WR_REQ: all valids 0 on the next edge and no rsp_valid.

Source files
------------

// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state type.
// Ports: none (package). Imported by axilite_master and the SRAM controller,
// so both ends of the bus agree on the response encoding.
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    MST_IDLE    = 3'd0,
    MST_WR_REQ  = 3'd1,
    MST_WR_RESP = 3'd2,
    MST_RD_REQ  = 3'd3,
    MST_RD_DATA = 3'd4,
    MST_RSP     = 3'd5
  } mst_state_e;

endpackage

// File: rtl/axilite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out.
// Ports: cmd_* request port (valid/ready), rsp_* response port (valid/ready),
//        m_axi_* AXI-Lite master channels AW/W/B/AR/R. clk, rst_n (async, active-low).
// Latency: cmd accepted at cycle 0 -> AXI valid at 1 -> rsp_valid at 3 with a zero-wait slave.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready.
module axilite_master
  import axilite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  // AXI-Lite write address
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // AXI-Lite write data
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // AXI-Lite write response
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // AXI-Lite read address
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // AXI-Lite read data
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  mst_state_e              state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    arvalid_q;
  logic                    aw_done_q;
  logic                    w_done_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;
  logic                    rsp_write_q;

  logic aw_fire, w_fire, aw_ok_d, w_ok_d;

  assign aw_fire = awvalid_q && m_axi_awready;
  assign w_fire  = wvalid_q && m_axi_wready;
  // A channel counts as complete if it finished earlier or finishes this cycle,
  // so AW and W may complete in either order or together.
  assign aw_ok_d = aw_done_q || aw_fire;
  assign w_ok_d  = w_done_q || w_fire;

  // Single address register serves both AW and AR; only one is ever in flight.
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_bready  = (state_q == MST_WR_RESP);
  assign m_axi_rready  = (state_q == MST_RD_DATA);

  assign cmd_ready = (state_q == MST_IDLE);
  assign rsp_valid = (state_q == MST_RSP);
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      rsp_write_q <= 1'b0;
    end else begin
      case (state_q)
        MST_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            if (cmd_write) begin
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= MST_WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= MST_RD_REQ;
            end
          end
        end
        MST_WR_REQ: begin
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_fire) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_ok_d && w_ok_d) begin
            state_q <= MST_WR_RESP;
          end
        end
        MST_WR_RESP: begin
          if (m_axi_bvalid) begin
            rsp_resp_q  <= m_axi_bresp;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b1;
            state_q     <= MST_RSP;
          end
        end
        MST_RD_REQ: begin
          if (arvalid_q && m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= MST_RD_DATA;
          end
        end
        MST_RD_DATA: begin
          if (m_axi_rvalid) begin
            rsp_rdata_q <= m_axi_rdata;
            rsp_resp_q  <= m_axi_rresp;
            rsp_write_q <= 1'b0;
            state_q     <= MST_RSP;
          end
        end
        MST_RSP: begin
          if (rsp_ready) begin
            state_q <= MST_IDLE;
          end
        end
        default: state_q <= MST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_master.sv
// Bench for axilite_master: a behavioural AXI-Lite memory slave (1024 words,
// SLVERR above 0x1000) with programmable per-channel delays, a directed vector
// table, hand sequences for stalls/backpressure/reset, and a random phase
// checked against a word-level reference memory.
module tb_axilite_master;
  import axilite_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0] m_axi_rdata = '0;

  axilite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int total = 0;
  int bad = 0;

  // ---------------- slave model ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_viol = 0;
  int n_awv_cyc = 0, n_wv_cyc = 0;
  logic [31:0] s_mem [1024];
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]  s_wstrb = '0;

  // Everything happens at the falling edge: handshakes of the previous rising
  // edge are reconstructed from the DUT outputs saved one half-cycle earlier.
  initial begin
    logic        aw_have, w_have, ar_have;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic        p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    logic [9:0]  widx;
    for (int i = 0; i < 1024; i++) s_mem[i] = '0;
    aw_have = 0; w_have = 0; ar_have = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_have = 0; w_have = 0; ar_have = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
      end else begin
        // AW
        if (p_awvalid && m_axi_awready) begin
          n_aw++; s_awaddr = p_awaddr; aw_have = 1; aw_wait = 0;
        end else if (p_awvalid) begin
          aw_wait++;
          if (!m_axi_awvalid || m_axi_awaddr !== p_awaddr) n_viol++;
        end
        // W
        if (p_wvalid && m_axi_wready) begin
          n_w++; s_wdata = p_wdata; s_wstrb = p_wstrb; w_have = 1; w_wait = 0;
        end else if (p_wvalid) begin
          w_wait++;
          if (!m_axi_wvalid || m_axi_wdata !== p_wdata || m_axi_wstrb !== p_wstrb) n_viol++;
        end
        // AR
        if (p_arvalid && m_axi_arready) begin
          n_ar++; s_araddr = p_araddr; ar_have = 1; ar_wait = 0;
        end else if (p_arvalid) begin
          ar_wait++;
          if (!m_axi_arvalid || m_axi_araddr !== p_araddr) n_viol++;
        end
        if (m_axi_bvalid && p_bready) begin n_b++; m_axi_bvalid = 0; end
        if (m_axi_rvalid && p_rready) begin n_r++; m_axi_rvalid = 0; end
        // write completion
        if (aw_have && w_have && !m_axi_bvalid) begin
          if (b_wait >= b_delay) begin
            if (s_awaddr < 32'h1000) begin
              widx = s_awaddr[11:2];
              for (int b = 0; b < 4; b++)
                if (s_wstrb[b]) s_mem[widx][8*b +: 8] = s_wdata[8*b +: 8];
              m_axi_bresp = RESP_OKAY;
            end else begin
              m_axi_bresp = RESP_SLVERR;
            end
            m_axi_bvalid = 1; aw_have = 0; w_have = 0; b_wait = 0;
          end else b_wait++;
        end
        // read completion
        if (ar_have && !m_axi_rvalid) begin
          if (r_wait >= r_delay) begin
            if (s_araddr < 32'h1000) begin
              m_axi_rdata = s_mem[s_araddr[11:2]]; m_axi_rresp = RESP_OKAY;
            end else begin
              m_axi_rdata = '0; m_axi_rresp = RESP_SLVERR;
            end
            m_axi_rvalid = 1; ar_have = 0; r_wait = 0;
          end else r_wait++;
        end
        if (m_axi_awvalid) n_awv_cyc++;
        if (m_axi_wvalid) n_wv_cyc++;
        p_awvalid = m_axi_awvalid; p_awaddr = m_axi_awaddr;
        p_wvalid = m_axi_wvalid; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
        p_arvalid = m_axi_arvalid; p_araddr = m_axi_araddr;
        p_bready = m_axi_bready; p_rready = m_axi_rready;
        m_axi_awready = m_axi_awvalid && !aw_have && (aw_wait >= aw_delay);
        m_axi_wready  = m_axi_wvalid && !w_have && (w_wait >= w_delay);
        m_axi_arready = m_axi_arvalid && !ar_have && (ar_wait >= ar_delay);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    if (a >= 32'h1000) return 32'h0;
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return 32'h0;
  endfunction

  function automatic logic [1:0] ref_resp(input logic [31:0] a);
    return (a >= 32'h1000) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (a < 32'h1000) begin
      w = ref_read(a);
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[int'(a >> 2)] = w;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one command (entered and left at a falling edge), waits for the
  // response, optionally stalls rsp_ready while re-offering commands.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int hold, input bit pester,
                        output logic [31:0] rdata, output logic [1:0] resp,
                        output logic rwr, output int lat);
    int n;
    rdata = 'x; resp = 'x; rwr = 1'bx; lat = -1;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_accept", 32'(cmd_ready), 32'h1);
    if (!cmd_ready) begin cmd_valid = 0; return; end
    @(negedge clk);
    cmd_valid = 0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("rsp_arrive", 32'(rsp_valid), 32'h1);
    if (!rsp_valid) return;
    rdata = rsp_rdata; resp = rsp_resp; rwr = rsp_write;
    for (int i = 0; i < hold; i++) begin
      if (pester) begin
        cmd_valid = 1; cmd_write = 1'($urandom); cmd_addr = $urandom;
      end
      @(negedge clk);
      chk("hold.rsp_valid", 32'(rsp_valid), 32'h1);
      chk("hold.cmd_ready", 32'(cmd_ready), 32'h0);
      chk("hold.rdata", rsp_rdata, rdata);
      chk("hold.resp", 32'(rsp_resp), 32'(resp));
      chk("hold.write", 32'(rsp_write), 32'(rwr));
    end
    cmd_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_consumed", 32'(rsp_valid), 32'h0);
    chk("idle_again", 32'(cmd_ready), 32'h1);
  endtask

  task automatic run_chk(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                         input int exp_lat, input int hold, input bit pester);
    int a0, w0, b0, ar0, r0, v0, lat;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        rwr;
    a0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r; v0 = n_viol;
    do_txn(wr, addr, wdata, strb, hold, pester, rdata, resp, rwr, lat);
    chk({tag, ".resp"}, 32'(resp), 32'(exp_resp));
    chk({tag, ".rdata"}, rdata, exp_rdata);
    chk({tag, ".rsp_write"}, 32'(rwr), 32'(wr));
    if (exp_lat >= 0) chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".aw_count"}, 32'(n_aw - a0), wr ? 32'h1 : 32'h0);
    chk({tag, ".w_count"}, 32'(n_w - w0), wr ? 32'h1 : 32'h0);
    chk({tag, ".b_count"}, 32'(n_b - b0), wr ? 32'h1 : 32'h0);
    chk({tag, ".ar_count"}, 32'(n_ar - ar0), wr ? 32'h0 : 32'h1);
    chk({tag, ".r_count"}, 32'(n_r - r0), wr ? 32'h0 : 32'h1);
    chk({tag, ".axi_rules"}, 32'(n_viol - v0), 32'h0);
    if (wr) begin
      chk({tag, ".awaddr"}, s_awaddr, addr);
      chk({tag, ".wdata"}, s_wdata, wdata);
      chk({tag, ".wstrb"}, 32'(s_wstrb), 32'(strb));
      ref_write(addr, wdata, strb);
    end else begin
      chk({tag, ".araddr"}, s_araddr, addr);
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n, a0, w0, b0, av0, wv0;
    logic        wr;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;

    vecs[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0000_0000, RESP_OKAY};
    vecs[1] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF,  RESP_OKAY};
    vecs[2] = '{1'b1, 32'h10,   32'h11112222, 4'h3, 32'h0000_0000, RESP_OKAY};
    vecs[3] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEAD2222,  RESP_OKAY};
    vecs[4] = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0000_0000, RESP_SLVERR};
    vecs[5] = '{1'b1, 32'h2000, 32'h55555555, 4'hF, 32'h0000_0000, RESP_SLVERR};
    vecs[6] = '{1'b0, 32'h14,   32'h0,        4'h0, 32'h0000_0000, RESP_OKAY};
    vecs[7] = '{1'b1, 32'h14,   32'hA5A5A5A5, 4'h8, 32'h0000_0000, RESP_OKAY};
    vecs[8] = '{1'b0, 32'h14,   32'h0,        4'h0, 32'hA500_0000,  RESP_OKAY};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst.awvalid", 32'(m_axi_awvalid), 32'h0);
    chk("rst.wvalid", 32'(m_axi_wvalid), 32'h0);
    chk("rst.arvalid", 32'(m_axi_arvalid), 32'h0);
    chk("rst.bready", 32'(m_axi_bready), 32'h0);
    chk("rst.rready", 32'(m_axi_rready), 32'h0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_resp", 32'(rsp_resp), 32'h0);
    chk("rst.rsp_write", 32'(rsp_write), 32'h0);
    chk("rst.awaddr", m_axi_awaddr, 32'h0);
    chk("rst.wdata", m_axi_wdata, 32'h0);
    chk("rst.wstrb", 32'(m_axi_wstrb), 32'h0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // directed vectors against a zero-wait slave
    for (int i = 0; i < 9; i++)
      run_chk($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
              vecs[i].exp_rdata, vecs[i].exp_resp, 3, 0, 1'b0);

    // AW stalled three cycles, W accepted immediately
    aw_delay = 3;
    av0 = n_awv_cyc; wv0 = n_wv_cyc;
    run_chk("aw_stall", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, RESP_OKAY, 6, 0, 1'b0);
    chk("aw_stall.awvalid_cycles", 32'(n_awv_cyc - av0), 32'h4);
    chk("aw_stall.wvalid_cycles", 32'(n_wv_cyc - wv0), 32'h1);
    aw_delay = 0;

    // response stalled five cycles while commands keep being offered
    run_chk("rsp_hold", 1'b1, 32'h24, 32'h0BADF00D, 4'hF, 32'h0, RESP_OKAY, 3, 5, 1'b1);
    run_chk("rsp_hold_rd", 1'b0, 32'h24, 32'h0, 4'h0, 32'h0BADF00D, RESP_OKAY, 3, 5, 1'b1);

    // reset while in WR_REQ
    aw_delay = 20;
    a0 = n_aw; w0 = n_w; b0 = n_b;
    cmd_write = 1; cmd_addr = 32'h28; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF; cmd_valid = 1;
    chk("wr_rst.accept", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 0;
    chk("wr_rst.awvalid_up", 32'(m_axi_awvalid), 32'h1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("wr_rst.awvalid_async", 32'(m_axi_awvalid), 32'h0);
    chk("wr_rst.wvalid_async", 32'(m_axi_wvalid), 32'h0);
    @(posedge clk);
    #1;
    chk("wr_rst.awvalid", 32'(m_axi_awvalid), 32'h0);
    chk("wr_rst.wvalid", 32'(m_axi_wvalid), 32'h0);
    chk("wr_rst.arvalid", 32'(m_axi_arvalid), 32'h0);
    chk("wr_rst.bready", 32'(m_axi_bready), 32'h0);
    chk("wr_rst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("wr_rst.cmd_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    rst_n = 1;
    aw_delay = 0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("wr_rst.no_rsp", 32'(n), 32'h0);
    chk("wr_rst.no_aw", 32'(n_aw - a0), 32'h0);
    chk("wr_rst.no_b", 32'(n_b - b0), 32'h0);
    run_chk("after_rst", 1'b0, 32'h28, 32'h0, 4'h0, 32'h0, RESP_OKAY, 3, 0, 1'b0);

    // random traffic with random slave and response delays
    for (int t = 0; t < 200; t++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
      r_delay = $urandom_range(0, 3);
      wr = 1'($urandom);
      if ($urandom_range(0, 7) == 0) addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      else addr = 32'($urandom_range(0, 15)) * 4;
      wdata = $urandom;
      strb = 4'($urandom_range(0, 15));
      run_chk($sformatf("rnd%0d", t), wr, addr, wdata, strb,
              wr ? 32'h0 : ref_read(addr), ref_resp(addr), -1,
              $urandom_range(0, 2), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
